// File: rtl/im_stage.sv
// Memory-access pipeline stage: drives the data bus for loads and stores, waits for
// the bus acknowledge (or aborts on timeout), extracts load data and registers writeback.
module im_stage #(
    parameter int WIDTH       = 32,
    parameter int RF_ADD_SIZE = 5,
    parameter int I_ADD_SIZE  = 32,
    parameter int TIMEOUT     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_im_valid,
    input  logic [WIDTH-1:0]       i_im_alu_out,
    input  logic [WIDTH-1:0]       i_im_write_data,
    input  logic                   i_im_mem_we,
    input  logic                   i_im_mem_re,
    input  logic [2:0]             i_im_funct3,
    input  logic                   i_im_rf_we_ctrl,
    input  logic [2:0]             i_im_rf_wb_src_ctrl,
    input  logic [WIDTH-1:0]       i_im_sx_data,
    input  logic [I_ADD_SIZE-1:0]  i_im_pc_plus_4,
    input  logic [RF_ADD_SIZE-1:0] i_im_dst,
    output logic                   o_dbus_req,
    output logic                   o_dbus_we,
    output logic [WIDTH-1:0]       o_dbus_addr,
    output logic [WIDTH-1:0]       o_dbus_wdata,
    output logic [3:0]             o_dbus_be,
    input  logic                   i_dbus_ack,
    input  logic [WIDTH-1:0]       i_dbus_rdata,
    output logic [WIDTH-1:0]       o_m_alu_out,
    output logic                   o_im_stall,
    output logic [WIDTH-1:0]       o_iwb_alu_out,
    output logic [WIDTH-1:0]       o_iwb_load_data,
    output logic [WIDTH-1:0]       o_iwb_sx_data,
    output logic [I_ADD_SIZE-1:0]  o_iwb_pc_plus_4,
    output logic [RF_ADD_SIZE-1:0] o_iwb_dst,
    output logic [2:0]             o_iwb_rf_wb_src_ctrl,
    output logic                   o_iwb_rf_we_ctrl,
    output logic                   o_iwb_misalign,
    output logic                   o_iwb_bus_err
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;

    logic [1:0] addr_lo;
    logic       access;
    logic       is_load;
    logic       is_byte;
    logic       is_half;
    logic       is_word;
    logic       misalign;
    logic       aligned_access;
    logic       timeout_abort;
    logic       load_done;

    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [WIDTH-1:0] load_ext;

    assign addr_lo = i_im_alu_out[1:0];
    assign access  = i_im_valid & (i_im_mem_we | i_im_mem_re);
    // A store wins when both enables are set.
    assign is_load = access & ~i_im_mem_we;

    // funct3[1:0] gives the access size; every code that is not byte or half is a word.
    assign is_byte = (i_im_funct3[1:0] == 2'b00);
    assign is_half = (i_im_funct3[1:0] == 2'b01);
    assign is_word = ~is_byte & ~is_half;

    assign misalign       = access & ((is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00)));
    assign aligned_access = access & ~misalign;

    // NOTE: the request is gated by reset directly so it drops the instant reset asserts,
    // even mid-transfer, rather than waiting for the state register to settle.
    assign o_dbus_req = i_rstn & (((state == IDLE) & aligned_access) | (state == BUSY));

    assign timeout_abort = (state == BUSY) & (wait_cnt == WAIT_LAST) & ~i_dbus_ack;
    assign o_im_stall    = o_dbus_req & ~i_dbus_ack & ~timeout_abort;
    assign load_done     = is_load & o_dbus_req & i_dbus_ack;

    assign o_m_alu_out = i_im_alu_out;
    assign o_dbus_we   = i_im_mem_we;
    assign o_dbus_addr = {i_im_alu_out[WIDTH-1:2], 2'b00};

    // Bus fields follow the stage inputs, which stay frozen by the stall while BUSY.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path
        // leaves it unassigned and infers a latch.
        o_dbus_be    = 4'b1111;
        o_dbus_wdata = i_im_write_data;
        if (is_byte) begin
            o_dbus_be    = 4'b0001 << addr_lo;
            o_dbus_wdata = {(WIDTH/8){i_im_write_data[7:0]}};
        end else if (is_half) begin
            o_dbus_be    = 4'b0011 << addr_lo;
            o_dbus_wdata = {(WIDTH/16){i_im_write_data[15:0]}};
        end
    end

    assign lane_byte = i_dbus_rdata[{addr_lo, 3'b000} +: 8];
    assign lane_half = i_dbus_rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = i_dbus_rdata;
        unique case (i_im_funct3)
            3'b000:  load_ext = {{(WIDTH-8){lane_byte[7]}}, lane_byte};
            3'b001:  load_ext = {{(WIDTH-16){lane_half[15]}}, lane_half};
            3'b100:  load_ext = {{(WIDTH-8){1'b0}}, lane_byte};
            3'b101:  load_ext = {{(WIDTH-16){1'b0}}, lane_half};
            default: load_ext = i_dbus_rdata;
        endcase
    end

    // wait_cnt counts cycles spent waiting for ack; it is 1 on the first BUSY cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!i_rstn) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (aligned_access && !i_dbus_ack) begin
                        state    <= BUSY;
                        wait_cnt <= 8'd1;
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (i_dbus_ack || timeout_abort) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_iwb_alu_out        <= '0;
            o_iwb_load_data      <= '0;
            o_iwb_sx_data        <= '0;
            o_iwb_pc_plus_4      <= '0;
            o_iwb_dst            <= '0;
            o_iwb_rf_wb_src_ctrl <= '0;
            o_iwb_rf_we_ctrl     <= 1'b0;
            o_iwb_misalign       <= 1'b0;
            o_iwb_bus_err        <= 1'b0;
        end else if (o_im_stall) begin
            // Bubble: only the qualifying flags matter while the data fields are ignored.
            o_iwb_rf_we_ctrl <= 1'b0;
            o_iwb_misalign   <= 1'b0;
            o_iwb_bus_err    <= 1'b0;
        end else begin
            o_iwb_alu_out        <= i_im_alu_out;
            o_iwb_load_data      <= load_done ? load_ext : '0;
            o_iwb_sx_data        <= i_im_sx_data;
            o_iwb_pc_plus_4      <= i_im_pc_plus_4;
            o_iwb_dst            <= i_im_dst;
            o_iwb_rf_wb_src_ctrl <= i_im_rf_wb_src_ctrl;
            o_iwb_rf_we_ctrl     <= i_im_rf_we_ctrl & ~misalign & ~timeout_abort;
            o_iwb_misalign       <= misalign;
            o_iwb_bus_err        <= timeout_abort;
        end
    end

endmodule

// File: tb/tb_im_stage.sv
// Randomized bench for im_stage: each instruction is scored against a transaction-level
// model that predicts bus fields, stall length, timeout and the writeback contents.
module tb_im_stage;

    localparam int WIDTH   = 32;
    localparam int RF      = 5;
    localparam int IA      = 32;
    localparam int TIMEOUT = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid, mem_we, mem_re, rf_we_ctrl, ack;
    logic [31:0]   alu_out, write_data, sx_data, pc_plus_4, rdata;
    logic [2:0]    funct3, wb_src;
    logic [RF-1:0] dst;

    logic          dbus_req, dbus_we, stall;
    logic [31:0]   dbus_addr, dbus_wdata, m_alu_out;
    logic [3:0]    dbus_be;
    logic [31:0]   iwb_alu_out, iwb_load_data, iwb_sx_data, iwb_pc_plus_4;
    logic [RF-1:0] iwb_dst;
    logic [2:0]    iwb_wb_src;
    logic          iwb_rf_we, iwb_misalign, iwb_bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    im_stage #(
        .WIDTH(WIDTH), .RF_ADD_SIZE(RF), .I_ADD_SIZE(IA), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rstn(rst_n),
        .i_im_valid(valid), .i_im_alu_out(alu_out), .i_im_write_data(write_data),
        .i_im_mem_we(mem_we), .i_im_mem_re(mem_re), .i_im_funct3(funct3),
        .i_im_rf_we_ctrl(rf_we_ctrl), .i_im_rf_wb_src_ctrl(wb_src),
        .i_im_sx_data(sx_data), .i_im_pc_plus_4(pc_plus_4), .i_im_dst(dst),
        .o_dbus_req(dbus_req), .o_dbus_we(dbus_we), .o_dbus_addr(dbus_addr),
        .o_dbus_wdata(dbus_wdata), .o_dbus_be(dbus_be),
        .i_dbus_ack(ack), .i_dbus_rdata(rdata),
        .o_m_alu_out(m_alu_out), .o_im_stall(stall),
        .o_iwb_alu_out(iwb_alu_out), .o_iwb_load_data(iwb_load_data),
        .o_iwb_sx_data(iwb_sx_data), .o_iwb_pc_plus_4(iwb_pc_plus_4),
        .o_iwb_dst(iwb_dst), .o_iwb_rf_wb_src_ctrl(iwb_wb_src),
        .o_iwb_rf_we_ctrl(iwb_rf_we), .o_iwb_misalign(iwb_misalign),
        .o_iwb_bus_err(iwb_bus_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Access size in bytes as a function of the access kind.
    function automatic int size_of(input logic [2:0] f3, input logic store);
        if (store) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int          sz   = size_of(f3, 1'b0);
        int          off  = int'(a % 4);
        logic [31:0] val  = 0;
        logic        sgn  = (f3 == 3'b000) || (f3 == 3'b001);
        for (int i = 0; i < sz; i++) val = val | (32'((rd >> (8 * (off + i))) & 32'hFF) << (8 * i));
        if (sgn && sz < 4 && val[8*sz-1]) val = val | ~((32'd1 << (8 * sz)) - 32'd1);
        return val;
    endfunction

    task automatic run_instr(input logic v, input logic we_i, input logic re_i,
                             input logic [2:0] f3_i, input logic [31:0] a_i,
                             input logic [31:0] wd_i, input logic [31:0] rd_i,
                             input int d, input logic rfwe_i);
        logic        acc, ld, mis, req, err;
        int          sz, n_stall;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_ld;
        valid = v; mem_we = we_i; mem_re = re_i; funct3 = f3_i; alu_out = a_i;
        write_data = wd_i; rdata = rd_i; rf_we_ctrl = rfwe_i;
        sx_data = $urandom; pc_plus_4 = $urandom; dst = RF'($urandom); wb_src = 3'($urandom);

        acc     = v && (we_i || re_i);
        ld      = acc && !we_i;
        sz      = size_of(f3_i, we_i);
        mis     = acc && (a_i % sz != 0);
        req     = acc && !mis;
        n_stall = !req ? 0 : (d < TIMEOUT - 1) ? d : TIMEOUT - 1;
        err     = req && (d >= TIMEOUT);
        exp_be  = 4'(((1 << sz) - 1) << (sz == 4 ? 0 : a_i % 4));
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd_i[8*(i % sz) +: 8];
        exp_ld  = (ld && req && !err) ? model_load(f3_i, a_i, rd_i) : 32'd0;

        for (int c = 0; c <= n_stall; c++) begin
            ack = req && (c == d);
            #1;
            check("req", 64'(dbus_req), 64'(req));
            check("stall", 64'(stall), 64'(c < n_stall));
            check("fwd", 64'(m_alu_out), 64'(a_i));
            if (req) begin
                check("addr", 64'(dbus_addr), 64'(a_i & 32'hFFFF_FFFC));
                check("be", 64'(dbus_be), 64'(exp_be));
                check("we", 64'(dbus_we), 64'(we_i));
                if (we_i) check("wdata", 64'(dbus_wdata), 64'(exp_wd));
            end
            @(posedge clk); #1;
            if (c < n_stall) begin
                check("bubble", {61'd0, iwb_rf_we, iwb_misalign, iwb_bus_err}, 64'd0);
            end else begin
                check("wb_alu", 64'(iwb_alu_out), 64'(a_i));
                check("wb_load", 64'(iwb_load_data), 64'(exp_ld));
                check("wb_sx", 64'(iwb_sx_data), 64'(sx_data));
                check("wb_pc", 64'(iwb_pc_plus_4), 64'(pc_plus_4));
                check("wb_ctl", {53'd0, iwb_dst, iwb_wb_src}, {53'd0, dst, wb_src});
                check("wb_flags", {61'd0, iwb_rf_we, iwb_misalign, iwb_bus_err},
                      {61'd0, rfwe_i && !mis && !err, mis, err});
            end
            @(negedge clk);
        end
        ack = 1'b0;
    endtask

    initial begin
        valid = 0; mem_we = 0; mem_re = 0; funct3 = 0; alu_out = 0; write_data = 0;
        rf_we_ctrl = 0; wb_src = 0; sx_data = 0; pc_plus_4 = 0; dst = 0; ack = 0; rdata = 0;
        #1;
        check("rst_req", 64'(dbus_req), 64'd0);
        check("rst_wb", {iwb_alu_out, iwb_load_data}, 64'd0);
        check("rst_wb_flags", {61'd0, iwb_rf_we, iwb_misalign, iwb_bus_err}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed scenarios: zero-wait LW, waited LB, SH, misaligned LW, timeout.
        run_instr(1, 0, 1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1);
        run_instr(1, 0, 1, 3'b000, 32'h103, 32'h0, 32'h80000000, 3, 1);
        run_instr(1, 1, 0, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 1, 0);
        run_instr(1, 0, 1, 3'b010, 32'h101, 32'h0, 32'h12345678, 0, 1);
        run_instr(1, 0, 1, 3'b010, 32'h104, 32'h0, 32'h55AA55AA, TIMEOUT + 5, 1);

        // A late ack after the abort, with no access pending, must be ignored.
        valid = 0; mem_re = 0; rf_we_ctrl = 0; ack = 1;
        #1;
        check("late_ack_req", 64'(dbus_req), 64'd0);
        check("late_ack_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        check("late_ack_wb", {61'd0, iwb_rf_we, iwb_misalign, iwb_bus_err}, 64'd0);
        @(negedge clk);
        ack = 0;

        // Reset in the middle of a waited load, then the same load completes normally.
        valid = 1; mem_we = 0; mem_re = 1; funct3 = 3'b010; alu_out = 32'h200; rf_we_ctrl = 1;
        repeat (3) begin
            #1 check("pre_rst_stall", 64'(stall), 64'd1);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 64'(dbus_req), 64'd0);
        check("mid_rst_wb", {iwb_alu_out, iwb_sx_data}, 64'd0);
        check("mid_rst_wb2", {iwb_load_data, iwb_pc_plus_4}, 64'd0);
        check("mid_rst_flags", {53'd0, iwb_dst, iwb_wb_src},  64'd0);
        check("mid_rst_flags2", {61'd0, iwb_rf_we, iwb_misalign, iwb_bus_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(1, 0, 1, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 2, 1);

        for (int n = 0; n < 150; n++) begin
            logic        v, we_r, re_r, rfwe_r;
            logic [2:0]  f3_r;
            int          kind, d_r;
            v      = ($urandom_range(0, 7) != 0);
            kind   = $urandom_range(0, 7);
            we_r   = (kind == 1) || (kind == 2) || (kind == 7);
            re_r   = (kind >= 3 && kind <= 6) || (kind == 7);
            f3_r   = we_r ? 3'($urandom_range(0, 2)) : 3'($urandom);
            d_r    = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 3)
                                                 : $urandom_range(0, 5);
            rfwe_r = v && $urandom_range(0, 1);
            run_instr(v, we_r, re_r, f3_r, $urandom, $urandom, $urandom, d_r, rfwe_r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
